// File: rtl/hdmi_pkg.sv
`default_nettype none
//==============================================================================
// Module      : hdmi_pkg
// Description : Shared types, constants and helpers for the HDMI packet scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
package hdmi_pkg;

    typedef logic [23:0]       hdmi_header_t;
    typedef logic [3:0][55:0]  hdmi_sub_t;

    localparam int PKT_PIXELS      = 32;
    localparam int MAX_ISLAND_PKTS = 18;

    localparam logic [7:0] NULL         = 8'h00;
    localparam logic [7:0] ACR          = 8'h01;
    localparam logic [7:0] AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] AVI          = 8'h82;
    localparam logic [7:0] SPD          = 8'h83;
    localparam logic [7:0] AUDIO_IF     = 8'h84;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    // A zero-length island request still produces one slot.
    function automatic logic [4:0] clamp_pkts(input logic [4:0] n, input logic [4:0] max_pkts);
        if (n == 5'd0)
            return 5'd1;
        else if (n > max_pkts)
            return max_pkts;
        else
            return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_packet_scheduler_if.sv
`default_nettype none
//==============================================================================
// Module      : hdmi_packet_scheduler_if
// Description : Source-side and encoder-side signal bundle of the packet scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
interface hdmi_packet_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC + 1)
) ();
    import hdmi_pkg::*;

    logic                        island_start;
    logic [4:0]                  island_num_packets;
    logic                        video_field_end;
    logic [NUM_SRC-1:0]          src_valid;
    hdmi_header_t [NUM_SRC-1:0]  src_header;
    hdmi_sub_t    [NUM_SRC-1:0]  src_sub;
    logic [NUM_SRC-1:0]          src_ack;
    logic                        island_active;
    logic                        packet_start;
    logic [4:0]                  packet_pixel_counter;
    logic [SRC_W-1:0]            packet_src;
    hdmi_header_t                header;
    hdmi_sub_t                   sub;

    modport master (
        output island_start, island_num_packets, video_field_end,
               src_valid, src_header, src_sub,
        input  src_ack, island_active, packet_start, packet_pixel_counter,
               packet_src, header, sub
    );

    modport slave (
        input  island_start, island_num_packets, video_field_end,
               src_valid, src_header, src_sub,
        output src_ack, island_active, packet_start, packet_pixel_counter,
               packet_src, header, sub
    );

endinterface
`default_nettype wire

// File: rtl/hdmi_pkt_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : hdmi_pkt_arbiter
// Description : Eligibility, once-per-field flags and source select.
//               PKT_SCHED_ROUND_ROBIN_EN rotates sources 1..NUM_SRC-1.
// Revision    : 1.0 - initial release
//==============================================================================
module hdmi_pkt_arbiter #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] ONCE_MASK = 4'b1100,
    parameter int                 SRC_W     = $clog2(NUM_SRC + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               grant_en,
    input  wire logic               field_end,
    input  wire logic [NUM_SRC-1:0] src_valid,
    output logic [NUM_SRC-1:0]      grant_oh,
    output logic [SRC_W-1:0]        grant_idx
);
    logic [NUM_SRC-1:0] r_sent;
    logic [NUM_SRC-1:0] w_sent_nxt;
    logic [NUM_SRC-1:0] w_elig;

    assign w_elig = src_valid & ~(ONCE_MASK & r_sent);

    // A grant coinciding with field end belongs to the new field, so set wins.
    always_comb begin
        w_sent_nxt = field_end ? '0 : r_sent;
        if (grant_en)
            w_sent_nxt = w_sent_nxt | (grant_oh & ONCE_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_sent <= '0;
        else
            r_sent <= w_sent_nxt;
    end

`ifdef PKT_SCHED_ROUND_ROBIN_EN
    logic [SRC_W-1:0] r_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= SRC_W'(NUM_SRC - 1);
        else if (grant_en && (grant_oh[NUM_SRC-1:1] != '0))
            r_last <= grant_idx;
    end

    // Two passes: sources above the last grant first, then wrap to 1.
    always_comb begin
        grant_oh  = '0;
        grant_idx = SRC_W'(NUM_SRC);
        if (w_elig[0]) begin
            grant_oh[0] = 1'b1;
            grant_idx   = '0;
        end else begin
            for (int i = 1; i < NUM_SRC; i++) begin
                if ((grant_oh == '0) && w_elig[i] && (i > int'(r_last))) begin
                    grant_oh[i] = 1'b1;
                    grant_idx   = SRC_W'(i);
                end
            end
            for (int i = 1; i < NUM_SRC; i++) begin
                if ((grant_oh == '0) && w_elig[i] && (i <= int'(r_last))) begin
                    grant_oh[i] = 1'b1;
                    grant_idx   = SRC_W'(i);
                end
            end
        end
    end
`else
    always_comb begin
        grant_oh  = '0;
        grant_idx = SRC_W'(NUM_SRC);
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((grant_oh == '0) && w_elig[i]) begin
                grant_oh[i] = 1'b1;
                grant_idx   = SRC_W'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/hdmi_packet_scheduler.sv
`default_nettype none
//==============================================================================
// Module      : hdmi_packet_scheduler
// Description : Fills data-island slots from prioritised sources or null packets.
//               Option macro: PKT_SCHED_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module hdmi_packet_scheduler
    import hdmi_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 MAX_PKTS  = 18,
    parameter logic [NUM_SRC-1:0] ONCE_MASK = 4'b1100,
    parameter int                 SRC_W     = $clog2(NUM_SRC + 1)
) (
    input wire logic                 clk_pixel,
    input wire logic                 rst,
    hdmi_packet_scheduler_if.slave   bus
);
    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic               w_latch;
    logic               w_last_pixel;
    logic [4:0]         r_cnt;
    logic [4:0]         r_slots_left;
    hdmi_header_t       r_header;
    hdmi_sub_t          r_sub;
    logic [SRC_W-1:0]   r_src;
    logic [NUM_SRC-1:0] r_ack;
    logic [NUM_SRC-1:0] w_grant_oh;
    logic [SRC_W-1:0]   w_grant_idx;
    hdmi_header_t       w_sel_header;
    hdmi_sub_t          w_sel_sub;

    assign w_last_pixel = (r_cnt == 5'(PKT_PIXELS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.island_start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_last_pixel) begin
                    if (r_slots_left > 5'd1)
                        w_latch = 1'b1;
                    else
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    hdmi_pkt_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .ONCE_MASK (ONCE_MASK),
        .SRC_W     (SRC_W)
    ) u_arbiter (
        .clk       (clk_pixel),
        .rst       (rst),
        .grant_en  (w_latch),
        .field_end (bus.video_field_end),
        .src_valid (bus.src_valid),
        .grant_oh  (w_grant_oh),
        .grant_idx (w_grant_idx)
    );

    // No grant leaves the selection at zero, which is the null packet.
    always_comb begin
        w_sel_header = '0;
        w_sel_sub    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_header = bus.src_header[i];
                w_sel_sub    = bus.src_sub[i];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_slots_left <= '0;
            r_header     <= '0;
            r_sub        <= '0;
            r_src        <= SRC_W'(NUM_SRC);
            r_ack        <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            if (w_latch)
                r_cnt <= '0;
            else if ((r_state == SEND) && !w_last_pixel)
                r_cnt <= r_cnt + 5'd1;
            if (w_latch) begin
                r_slots_left <= (r_state == IDLE)
                              ? clamp_pkts(bus.island_num_packets, 5'(MAX_PKTS))
                              : r_slots_left - 5'd1;
                r_header     <= w_sel_header;
                r_sub        <= w_sel_sub;
                r_src        <= w_grant_idx;
                r_ack        <= w_grant_oh;
            end
        end
    end

    assign bus.island_active        = (r_state == SEND);
    assign bus.packet_start         = (r_state == SEND) && (r_cnt == 5'd0);
    assign bus.packet_pixel_counter = r_cnt;
    assign bus.packet_src           = r_src;
    assign bus.header               = r_header;
    assign bus.sub                  = r_sub;
    assign bus.src_ack              = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_packet_scheduler.sv
`default_nettype none
//==============================================================================
// Module      : tb_hdmi_packet_scheduler
// Description : Directed scoreboard bench for hdmi_packet_scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_hdmi_packet_scheduler;
    import hdmi_pkg::*;

    localparam int NUM_SRC  = 4;
    localparam int SRC_W    = 3;
    localparam int NULL_SRC = NUM_SRC;

    logic clk_pixel = 1'b0;
    logic rst       = 1'b1;
    always #5 clk_pixel = ~clk_pixel;

    hdmi_packet_scheduler_if #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) bus ();

    hdmi_packet_scheduler #(
        .NUM_SRC   (NUM_SRC),
        .MAX_PKTS  (18),
        .ONCE_MASK (4'b1100),
        .SRC_W     (SRC_W)
    ) dut (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .bus       (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int active_cycles = 0;
    logic prev_active = 1'b0;
    int prev_cnt = 0;

    function automatic hdmi_header_t src_hdr(input int i);
        logic [7:0] t;
        case (i)
            0:       t = ACR;
            1:       t = AUDIO_SAMPLE;
            2:       t = AVI;
            default: t = SPD;
        endcase
        return {8'(8'h40 + i), 8'(8'hC0 | i), t};
    endfunction

    function automatic hdmi_sub_t src_sub_val(input int i);
        hdmi_sub_t s;
        for (int j = 0; j < 4; j++)
            s[j] = {8'(i + 1), 8'(j + 16), 40'hA55AC33C0F};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: one expected source per slot, popped at each slot start.
    always @(negedge clk_pixel) begin
        int ec;
        int s;
        logic [255:0] eh;
        logic [255:0] es;
        logic [255:0] ea;
        if (bus.island_active === 1'b1) begin
            ec = prev_active ? ((prev_cnt + 1) % 32) : 0;
            active_cycles++;
            chk("pixel_counter", 256'(bus.packet_pixel_counter), 256'(ec));
            chk("packet_start", 256'(bus.packet_start), 256'(ec == 0));
            if (ec == 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_slot", 256'(bus.packet_src), 256'(NULL_SRC + 1));
                end else begin
                    s  = exp_q.pop_front();
                    eh = (s == NULL_SRC) ? '0 : 256'(src_hdr(s));
                    es = (s == NULL_SRC) ? '0 : 256'(src_sub_val(s));
                    ea = (s == NULL_SRC) ? '0 : (256'(1) << s);
                    chk("packet_src", 256'(bus.packet_src), 256'(s));
                    chk("header", 256'(bus.header), eh);
                    chk("sub", 256'(bus.sub), es);
                    chk("ack_at_slot", 256'(bus.src_ack), ea);
                end
            end else begin
                chk("ack_mid_slot", 256'(bus.src_ack), '0);
            end
            prev_cnt = ec;
        end else begin
            chk("ack_outside", 256'(bus.src_ack), '0);
        end
        prev_active = (bus.island_active === 1'b1);
    end

    task automatic start_island(input int n, input logic fe);
        @(negedge clk_pixel);
        bus.island_start       = 1'b1;
        bus.island_num_packets = 5'(n);
        bus.video_field_end    = fe;
        @(negedge clk_pixel);
        bus.island_start       = 1'b0;
        bus.video_field_end    = 1'b0;
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while ((bus.island_active === 1'b1) && (k < 700)) begin
            @(negedge clk_pixel);
            k++;
        end
        chk("island_timeout", 256'(k >= 700), '0);
    endtask

    task automatic run_island(input int n, input logic fe, input int slots);
        active_cycles = 0;
        start_island(n, fe);
        wait_end();
        chk("active_cycles", 256'(active_cycles), 256'(32 * slots));
        chk("queue_drained", 256'(exp_q.size()), '0);
    endtask

    task automatic pulse_fe();
        @(negedge clk_pixel);
        bus.video_field_end = 1'b1;
        @(negedge clk_pixel);
        bus.video_field_end = 1'b0;
    endtask

    initial begin
        bus.island_start       = 1'b0;
        bus.island_num_packets = '0;
        bus.video_field_end    = 1'b0;
        bus.src_valid          = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_header[i] = src_hdr(i);
            bus.src_sub[i]    = src_sub_val(i);
        end

        // Reset values
        repeat (3) @(negedge clk_pixel);
        chk("rst_active", 256'(bus.island_active), '0);
        chk("rst_start", 256'(bus.packet_start), '0);
        chk("rst_counter", 256'(bus.packet_pixel_counter), '0);
        chk("rst_src", 256'(bus.packet_src), 256'(NULL_SRC));
        chk("rst_header", 256'(bus.header), '0);
        chk("rst_sub", 256'(bus.sub), '0);
        chk("rst_ack", 256'(bus.src_ack), '0);
        rst = 1'b0;

        // Sources 1..3 pending, source 0 idle
        bus.src_valid = 4'b1110;
`ifdef PKT_SCHED_ROUND_ROBIN_EN
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
`else
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
`endif
        run_island(3, 1'b0, 3);
        pulse_fe();

        // Single source 1, two slots
        bus.src_valid = 4'b0010;
        exp_q.push_back(1); exp_q.push_back(1);
        run_island(2, 1'b0, 2);

        // Everyone pending: source 0 always wins
        bus.src_valid = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        run_island(3, 1'b0, 3);

        // Once-per-field source 2
        bus.src_valid = 4'b0100;
        exp_q.push_back(2); exp_q.push_back(NULL_SRC);
        run_island(2, 1'b0, 2);
        exp_q.push_back(NULL_SRC);
        run_island(1, 1'b0, 1);
        pulse_fe();
        exp_q.push_back(2);
        run_island(1, 1'b0, 1);
        pulse_fe();

        // Clamp boundaries
        bus.src_valid = 4'b0010;
        exp_q.push_back(1);
        run_island(0, 1'b0, 1);
        for (int i = 0; i < 18; i++) exp_q.push_back(1);
        run_island(25, 1'b0, 18);

        // island_start mid-island is ignored
        exp_q.push_back(1); exp_q.push_back(1);
        active_cycles = 0;
        start_island(2, 1'b0);
        repeat (10) @(negedge clk_pixel);
        chk("mid_counter", 256'(bus.packet_pixel_counter), 256'(10));
        bus.island_start       = 1'b1;
        bus.island_num_packets = 5'd5;
        @(negedge clk_pixel);
        bus.island_start = 1'b0;
        wait_end();
        chk("mid_start_cycles", 256'(active_cycles), 256'(64));
        chk("mid_start_queue", 256'(exp_q.size()), '0);

        // Field end coincident with a source 3 grant leaves source 3 marked
        bus.src_valid = 4'b1000;
        exp_q.push_back(3); exp_q.push_back(NULL_SRC);
        run_island(2, 1'b1, 2);
        exp_q.push_back(NULL_SRC);
        run_island(1, 1'b0, 1);
        pulse_fe();

        // Reset at counter 17 of the third slot
        bus.src_valid = 4'b0010;
        for (int i = 0; i < 4; i++) exp_q.push_back(1);
        start_island(4, 1'b0);
        repeat (81) @(negedge clk_pixel);
        chk("pre_rst_counter", 256'(bus.packet_pixel_counter), 256'(17));
        rst = 1'b1;
        @(negedge clk_pixel);
        chk("mid_rst_active", 256'(bus.island_active), '0);
        chk("mid_rst_header", 256'(bus.header), '0);
        chk("mid_rst_src", 256'(bus.packet_src), 256'(NULL_SRC));
        chk("mid_rst_ack", 256'(bus.src_ack), '0);
        chk("mid_rst_counter", 256'(bus.packet_pixel_counter), '0);
        rst = 1'b0;
        chk("mid_rst_left", 256'(exp_q.size()), 256'(1));
        exp_q.delete();
        repeat (40) @(negedge clk_pixel);

        // Normal operation after reset
        exp_q.push_back(1);
        run_island(1, 1'b0, 1);

        repeat (4) @(negedge clk_pixel);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdmi_packet_scheduler.md
Name: hdmi_packet_scheduler

Overview:
Parametrised successor to the single-header HDMI packet picker. Arbitrates NUM_SRC packet sources (ACR, audio sample, AVI/SPD/audio infoframes, ...) into back-to-back 32-pixel packet slots during a data island period. Presents one latched header plus four subpackets per slot to the TERC4/BCH encoder. Enforces once-per-field delivery for infoframe sources and inserts null packets when no source is pending.

Parameters:
NUM_SRC, 4, number of packet sources; index 0 has the highest priority.
MAX_PKTS, 18, maximum packets per data island; requests above this are clamped.
ONCE_MASK, 4'b1100, bit i set means source i may be granted at most once per video field.
SRC_W, $clog2(NUM_SRC+1), width of packet_src; the value NUM_SRC means null packet.

Ports:
clk_pixel  in  1  pixel clock.
rst  in  1  synchronous, active-high reset.
island_start  in  1  one-cycle pulse requesting a data island.
island_num_packets  in  5  packet count, sampled with island_start.
video_field_end  in  1  one-cycle pulse at the end of a field; clears once-per-field flags.
src_valid  in  NUM_SRC  per-source packet pending.
src_header  in  NUM_SRC x 24  per-source header (HB0..HB2).
src_sub  in  NUM_SRC x 4 x 56  per-source subpackets.
src_ack  out  NUM_SRC  one-cycle pulse when the source's packet is latched.
island_active  out  1  high while a slot is being output.
packet_start  out  1  high when packet_pixel_counter==0 and island_active is high.
packet_pixel_counter  out  5  pixel index within the current slot, 0..31.
packet_src  out  SRC_W  source of the current slot.
header  out  24  latched header.
sub  out  4 x 56  latched subpackets.

Behaviour:
- Reset values: state IDLE; all outputs 0 except packet_src=NUM_SRC; sent flags 0.
- States:
  - IDLE: island_start=1 -> arbitrate, latch winner, slots_left=clamp(island_num_packets), counter=0 -> SEND.
  - SEND: counter increments every cycle. At counter==31:
    - if slots_left>1: arbitrate, latch, slots_left-1, counter wraps to 0, stay in SEND;
    - else -> IDLE. Counter, header and sub hold their last values; island_active=0.
- Clamp rule: 0 is treated as 1; values above MAX_PKTS become MAX_PKTS.
- Latency: header/sub/packet_src are valid on the cycle after island_start. Island length is exactly 32*N cycles of island_active, with no gaps between slots.
- Arbitration, evaluated only at latch edges:
  - eligible(i) = src_valid[i] && !(ONCE_MASK[i] && sent[i]).
  - Default: lowest eligible index wins.
  - If none is eligible: null packet, header=0, sub=0, packet_src=NUM_SRC, no ack.
- src_ack[winner] pulses in the cycle after the latch edge. The source must hold its data stable until it sees the ack, and may deassert valid the cycle after the ack.
- sent[i] is set on the grant of a masked source. video_field_end clears all flags. If a grant and video_field_end occur in the same cycle, the flag ends up set (the grant belongs to the new field).
- island_start is ignored while in SEND.
- rst asserted mid-island: immediate return to IDLE, all outputs take reset values, no ack is issued.
- Sources are never dropped. An ineligible or losing source keeps src_valid high and waits.

Optional Feature:
Macro PKT_SCHED_ROUND_ROBIN_EN.
- Defined: source 0 keeps absolute priority. Sources 1..NUM_SRC-1 rotate: search starts one above the last granted non-zero source and wraps.
- Undefined: strict fixed priority by index; no rotation pointer is synthesised.
- Null insertion and once-per-field rules are identical in both builds.

Decomposition:
- Package hdmi_pkg holds:
  - typedef hdmi_header_t (logic [23:0]);
  - typedef hdmi_sub_t (logic [3:0][55:0]);
  - localparam PKT_PIXELS=32;
  - localparam MAX_ISLAND_PKTS=18;
  - packet type constants: NULL=8'h00, ACR=8'h01, AUDIO_SAMPLE=8'h02, AVI=8'h82, SPD=8'h83, AUDIO_IF=8'h84.
- One natural sub-module, hdmi_pkt_arbiter: combinational eligibility and priority/round-robin select, which also owns the rotation pointer register.

Test Plan:
- NUM_SRC=4, only src_valid[1]=1, island_num_packets=2 -> two slots, both packet_src=1, two acks 32 cycles apart, island_active high exactly 64 cycles.
- All src_valid=1, island_num_packets=3, default build -> slots 0,0,0; with PKT_SCHED_ROUND_ROBIN_EN and src0 idle -> 1,2,3.
- src_valid[2]=1 continuously (masked), island_num_packets=2 -> slot0 src 2, slot1 null (header 24'h000000); after a video_field_end pulse the next island grants src 2 again.
- island_num_packets=0 -> 1 slot (32 cycles); island_num_packets=25 -> 18 slots (576 cycles).
- island_start pulsed at counter=10 mid-island -> ignored, slot count unchanged; video_field_end coincident with a src 3 grant -> sent[3]=1 afterwards.
- rst asserted at counter=17 of slot 2 -> next cycle IDLE, header=0, packet_src=NUM_SRC, no ack; a later island_start operates normally.
